// File: rtl/approx_serial_add_if.sv
// Handshake bundle for the approximate bit-serial adder.
// Operands flow in through in_valid/in_ready; results flow out through out_valid/out_ready.
interface approx_serial_add_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, c_out
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, c_out
  );
endinterface

// File: rtl/approx_serial_add.sv
// Bit-serial adder, LSB first, one bit per clock.
// The low APPROX_BITS positions use OR for the sum and drop the incoming carry.
module approx_serial_add #(
  parameter int WIDTH       = 32,
  parameter int APPROX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  approx_serial_add_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW:0]   AB   = (CW + 1)'(APPROX_BITS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_q;

  logic approx;
  logic sbit;
  logic ncarry;

  always_comb begin
    approx = ({1'b0, cnt} < AB);
    sbit   = 1'b0;
    ncarry = 1'b0;
    if (approx) begin
      sbit   = a_q[0] | b_q[0];
      ncarry = a_q[0] & b_q[0];
    end else begin
      sbit   = a_q[0] ^ b_q[0] ^ carry;
      ncarry = (a_q[0] & b_q[0]) |
               (a_q[0] & carry)  |
               (b_q[0] & carry);
    end
  end

  // a_q doubles as the sum shift register: each sum bit enters at the
  // top as the consumed operand bit leaves at the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      c_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            cnt   <= '0;
            carry <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          a_q   <= {sbit, a_q[WIDTH-1:1]};
          b_q   <= b_q >> 1;
          carry <= ncarry;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum_q <= {sbit, a_q[WIDTH-1:1]};
            c_q   <= ncarry;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_q;

endmodule

// File: tb/tb_approx_serial_add.sv
// Directed and random checks of approx_serial_add at WIDTH=8.
// Three instances (APPROX_BITS 4, 0, 8) share one stimulus stream.
module tb_approx_serial_add;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a;
  logic [7:0] b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  approx_serial_add_if #(.WIDTH(8)) if4 ();
  approx_serial_add_if #(.WIDTH(8)) if0 ();
  approx_serial_add_if #(.WIDTH(8)) if8 ();

  assign if4.in_valid  = in_valid;
  assign if4.a         = a;
  assign if4.b         = b;
  assign if4.out_ready = out_ready;
  assign if0.in_valid  = in_valid;
  assign if0.a         = a;
  assign if0.b         = b;
  assign if0.out_ready = out_ready;
  assign if8.in_valid  = in_valid;
  assign if8.a         = a;
  assign if8.b         = b;
  assign if8.out_ready = out_ready;

  approx_serial_add #(.WIDTH(8), .APPROX_BITS(4)) u4 (
    .clk(clk), .rst(rst), .bus(if4.slave)
  );
  approx_serial_add #(.WIDTH(8), .APPROX_BITS(0)) u0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );
  approx_serial_add #(.WIDTH(8), .APPROX_BITS(8)) u8 (
    .clk(clk), .rst(rst), .bus(if8.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair and wait for out_valid; DUT is left in DONE.
  task automatic do_op(input logic [7:0] oa, input logic [7:0] ob,
                       output int lat);
    int w;
    w = 0;
    while (!if4.in_ready && w < 20) begin
      step();
      w++;
    end
    n_assert++;
    if (!if4.in_ready) begin
      n_fail++;
      $display("FAIL op_ready: in_ready=%b required 1", if4.in_ready);
    end
    in_valid = 1'b1;
    a = oa;
    b = ob;
    step();
    in_valid = 1'b0;
    a = ~oa;
    b = ~ob;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!if4.out_valid && lat < 40);
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic chk8(input string name, input logic [7:0] got,
                      input logic [7:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got,
                      input logic exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 8'h00;
    b = 8'h00;
    step();
    step();
    rst = 1'b0;
    chk1("reset_in_ready", if4.in_ready, 1'b1);
    chk1("reset_out_valid", if4.out_valid, 1'b0);
    chk8("reset_sum", if4.sum, 8'h00);
    chk1("reset_c_out", if4.c_out, 1'b0);
  endtask

  task automatic test_directed();
    int lat;
    do_op(8'h0F, 8'h01, lat);
    n_assert++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL latency_0f01: got %0d required 8", lat);
    end
    chk8("sum4_0f01", if4.sum, 8'h0F);
    chk1("c4_0f01", if4.c_out, 1'b0);
    chk8("sum0_0f01", if0.sum, 8'h10);
    chk8("sum8_0f01", if8.sum, 8'h0F);
    finish_op();
    do_op(8'hFF, 8'hFF, lat);
    chk8("sum4_ffff", if4.sum, 8'hFF);
    chk1("c4_ffff", if4.c_out, 1'b1);
    chk8("sum0_ffff", if0.sum, 8'hFE);
    chk1("c0_ffff", if0.c_out, 1'b1);
    chk8("sum8_ffff", if8.sum, 8'hFF);
    chk1("c8_ffff", if8.c_out, 1'b1);
    finish_op();
    do_op(8'h18, 8'h08, lat);
    chk8("sum4_1808", if4.sum, 8'h28);
    chk1("c4_1808", if4.c_out, 1'b0);
    finish_op();
  endtask

  task automatic test_stall();
    int lat;
    do_op(8'h5A, 8'h33, lat);
    in_valid = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    for (int i = 0; i < 5; i++) begin
      step();
      chk8("stall_sum", if4.sum, 8'h8B);
      chk1("stall_c_out", if4.c_out, 1'b0);
      chk1("stall_in_ready", if4.in_ready, 1'b0);
      chk1("stall_out_valid", if4.out_valid, 1'b1);
    end
    in_valid = 1'b0;
    finish_op();
    chk1("release_in_ready", if4.in_ready, 1'b1);
    chk1("release_out_valid", if4.out_valid, 1'b0);
    chk8("idle_hold_sum", if4.sum, 8'h8B);
  endtask

  task automatic test_mid_reset();
    int lat;
    int seen;
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'h01;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    chk8("run_hold_sum", if4.sum, 8'h8B);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("midrst_in_ready", if4.in_ready, 1'b1);
    chk1("midrst_out_valid", if4.out_valid, 1'b0);
    chk8("midrst_sum", if4.sum, 8'h00);
    chk1("midrst_c_out", if4.c_out, 1'b0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (if4.out_valid) seen++;
    end
    n_assert++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midrst_ghost: out_valid cycles %0d required 0", seen);
    end
    do_op(8'h21, 8'h12, lat);
    n_assert++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL latency_2112: got %0d required 8", lat);
    end
    chk8("sum4_2112", if4.sum, 8'h33);
    chk1("c4_2112", if4.c_out, 1'b0);
    finish_op();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [8:0] ex;
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op(ra, rb, lat);
      n_assert++;
      if (lat !== 8) begin
        n_fail++;
        $display("FAIL rand_latency: got %0d required 8", lat);
      end
      ex = {1'b0, ra} + {1'b0, rb};
      chk8("rand_sum0", if0.sum, ex[7:0]);
      chk1("rand_c0", if0.c_out, ex[8]);
      chk8("rand_sum8", if8.sum, ra | rb);
      chk1("rand_c8", if8.c_out, ra[7] & rb[7]);
      finish_op();
      chk1("rand_b2b_ready", if4.in_ready, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_serial_add.md
APPROX_SERIAL_ADD -- requirements
Module: approx_serial_add

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal: WIDTH >= 2).
REQ-002 The block SHALL have parameter APPROX_BITS, default 4, giving the number of low-order approximate bit positions (legal: 0 <= APPROX_BITS <= WIDTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands a/b are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port out_valid, output, 1 bit: sum/c_out hold a completed result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: the approximate sum.
REQ-012 The block SHALL have port c_out, output, 1 bit: the carry out of bit WIDTH-1.

Function
REQ-013 The block SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE: in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 In IDLE, the block SHALL capture a, b on an edge where in_valid=1, clear the bit counter and carry register, and enter RUN.
REQ-015 In RUN, the block SHALL process exactly one bit per cycle, LSB first (bit index i = counter value), shifting the sum bit into a shift register.
REQ-016 For i < APPROX_BITS, the block SHALL compute sum_i = a_i | b_i and set next carry = a_i & b_i, ignoring the incoming carry.
REQ-017 For i >= APPROX_BITS, the block SHALL compute an exact full add: sum_i = a_i ^ b_i ^ carry, next carry = majority(a_i, b_i, carry).
REQ-018 After the edge that processes bit WIDTH-1, the block SHALL load sum and c_out (final carry) into output registers and enter DONE; out_valid SHALL rise exactly WIDTH cycles after the accept edge.
REQ-019 In DONE, the block SHALL hold sum and c_out stable until an edge with out_ready=1, then enter IDLE; out_ready=0 SHALL stall indefinitely with no loss.
REQ-020 sum and c_out SHALL change only on entry to DONE (or reset) and SHALL hold their last values in IDLE and RUN.
REQ-021 The block SHALL ignore in_valid in RUN and DONE; operand inputs SHALL NOT affect an operation in flight after capture.
REQ-022 APPROX_BITS=0 SHALL give the exact sum {c_out,sum}=a+b; APPROX_BITS=WIDTH SHALL give sum=a|b and c_out=a[WIDTH-1]&b[WIDTH-1].
REQ-023 Minimum operation period SHALL be WIDTH+2 cycles (accept, WIDTH RUN edges, DONE handshake); back-to-back acceptance in the cycle after DONE exit SHALL be supported.

Reset
REQ-024 On an edge with rst=1, the block SHALL enter IDLE, set in_ready=1, out_valid=0, sum=0, c_out=0, and clear the counter, carry and shift register.
REQ-025 rst SHALL take priority over all other inputs; reset mid-RUN or in DONE SHALL discard the operation with no later out_valid for it.

Verification (WIDTH=8, APPROX_BITS=4)
REQ-026 The bench SHALL apply a=0x0F, b=0x01 -> required: out_valid 8 cycles after accept, sum=0x0F, c_out=0 (exact would be 0x10).
REQ-027 The bench SHALL apply a=0xFF, b=0xFF -> required: sum=0xFF, c_out=1; a=0x18, b=0x08 -> required: sum=0x28, c_out=0.
REQ-028 The bench SHALL hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands applied -> required: sum/c_out stable, in_ready=0, no new accept; out_ready=1 -> IDLE on the next edge.
REQ-029 The bench SHALL assert rst for 1 cycle at RUN bit 3 -> required: next cycle in_ready=1, out_valid=0, sum=0x00; the next operation a=0x21, b=0x12 -> required: sum=0x33, c_out=0.
REQ-030 The bench SHALL run 1000 random operand pairs with APPROX_BITS=0 and APPROX_BITS=8 -> required: results match a+b and a|b (with c_out=a[7]&b[7]) respectively, and the cycle count per operation is constant.
